spi_deserializer: RTL and testbench
===================================

# spi_deserializer

SPI peripheral-side receive path: synchronizes the raw SCK/CS_N/MOSI pins into the `clk` domain, detects SCK and CS_N edges, and shifts MOSI MSB-first into DW-bit words. Completed words are presented on a valid/ready output register. The block also exports the edge strobes, so the peripheral's MISO serializer shifts in lockstep with this receiver. It sits between the SPI pins and the command/register decode logic.

## Interface
Parameters:
- DW, 8, word width in bits (≥2)
- CPOL, 0, SCK idle level
- CPHA, 0, SPI clock phase; sample edge is rising when CPOL==CPHA, falling otherwise
- SYNC_STAGES, 2, synchronizer flops per pin input (≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- sck_i  in  1  raw SPI clock pin (asynchronous)
- cs_n_i  in  1  raw chip select pin, active-low (asynchronous)
- mosi_i  in  1  raw MOSI pin (asynchronous)
- data_o  out  DW  received word
- valid_o  out  1  data_o holds an unconsumed word
- ready_i  in  1  consumer accepts data_o when valid_o && ready_i
- overrun_o  out  1  one-cycle pulse: word completed while output register full and not being consumed; the new word is dropped
- frame_err_o  out  1  one-cycle pulse: CS_N deasserted with a partial word (bit count ≠ 0)
- busy_o  out  1  synchronized CS_N is low
- sck_sample_edge_o  out  1  one-cycle strobe, SCK sample edge while selected
- sck_shift_edge_o  out  1  one-cycle strobe, SCK shift edge while selected
- cs_n_falling_edge_o  out  1  one-cycle strobe, CS_N asserted
- cs_n_rising_edge_o  out  1  one-cycle strobe, CS_N deasserted

## Operation
- Sync: each pin passes through a SYNC_STAGES flop chain plus one history flop. On reset, the chains and history flops load the idle levels (CS_N=1, SCK=CPOL, MOSI=0), so no strobe fires in the first cycles after reset.
- Edge strobes: an edge is detected when the last sync stage differs from the history flop. SCK strobes are gated by synchronized CS_N low; CS_N strobes are ungated. MOSI uses the same sync depth, so the sampled bit is aligned with its sample strobe.
- Shift: on sck_sample_edge, shreg <= {shreg[DW-2:0], mosi_sync} and bit_cnt increments (width clog2(DW)).
- Word completion: a sample edge with bit_cnt == DW-1 completes a word. bit_cnt wraps to 0, and back-to-back words in one frame are supported.
  - Output register empty, or consumed in the same cycle (valid_o && ready_i): load data_o with the completed word and hold valid_o = 1.
  - Otherwise: pulse overrun_o. data_o and valid_o are unchanged.
- Consume: valid_o && ready_i with no completion in that cycle clears valid_o next cycle. data_o keeps its last value.
- cs_n_falling_edge: clears bit_cnt and shreg.
- cs_n_rising_edge: clears bit_cnt. If bit_cnt ≠ 0 at that point, pulse frame_err_o and discard the partial word. valid_o/data_o are unaffected.
- Simultaneous events:
  - A CS_N strobe and an SCK strobe cannot both be counted, because SCK strobes are gated by CS_N low. A CS_N rise masks an SCK edge in the same cycle.
  - Completion and consume in the same cycle: no overrun.
- Reset mid-frame: all state returns to reset values. The frame's remaining bits are ignored until the next CS_N falling edge, because bit_cnt restarts only there or from 0.

## Timing
- Reset values: data_o=0, valid_o=0, overrun_o=0, frame_err_o=0, busy_o=0, all strobes 0, bit_cnt=0, shreg=0.
- Pin-to-strobe latency: a strobe is asserted SYNC_STAGES+1 clk edges after the first clk edge that captures the new pin level. Total uncertainty is 1 clk.
- Strobes are exactly 1 cycle wide.
- Completion latency: valid_o and data_o update on the clk edge after the final sck_sample_edge_o cycle. overrun_o pulses in that same cycle.
- frame_err_o pulses on the clk edge after the cs_n_rising_edge_o cycle.
- busy_o follows the last sync stage inverted. It has the same latency as the strobes minus the history flop.
- Constraint: every SCK high and low phase and every MOSI setup/hold must span ≥ 2 clk periods, i.e. f_clk ≥ 4·f_sck. Behaviour is undefined otherwise.
- Outputs are registered; there is no combinational path from ready_i to any output.

## Test plan
- Mode 0, DW=8, f_clk=8·f_sck: one frame sending 0xA5 with ready_i=1 → one valid_o pulse with data_o=0xA5, then valid_o falls; frame_err_o and overrun_o stay 0.
- Back-to-back 0x3C, 0xC3 in one frame with ready_i=1 → two valid_o words in order, bit_cnt=0 at the CS_N rise, no frame_err_o.
- Overrun: ready_i=0, send 0x11 then 0x22 → data_o stays 0x11, valid_o stays 1, exactly one overrun_o pulse when the 8th bit of 0x22 is sampled.
- Partial frame: 5 bits then CS_N high → frame_err_o single pulse, no valid_o. The next full frame 0x7E is received correctly.
- Modes 1/2/3 (CPOL/CPHA sweep): send 0x96 in each → data_o=0x96. Sample strobes occur only on the correct SCK edge polarity.
- Reset mid-frame after 4 bits, then a fresh frame 0x5A → all outputs 0 after reset, no spurious strobes, data_o=0x5A afterward.

Source files
------------

// File: rtl/spi_deserializer.sv
// SPI peripheral receive path: pin synchronizers, SCK/CS_N edge strobes,
// MSB-first shift into DW-bit words presented on a valid/ready register.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   sck_i/cs_n_i/mosi_i raw asynchronous SPI pins
//   data_o/valid_o      received word and its valid flag
//   ready_i             consumer accepts data_o when valid_o && ready_i
//   overrun_o           pulse: completed word dropped (register full)
//   frame_err_o         pulse: CS_N rose with a partial word
//   busy_o              synchronized CS_N is low
//   sck_*_edge_o        SCK sample/shift strobes while selected
//   cs_n_*_edge_o       CS_N falling/rising strobes
module spi_deserializer #(
    parameter int DW          = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sck_i,
    input  logic          cs_n_i,
    input  logic          mosi_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          overrun_o,
    output logic          frame_err_o,
    output logic          busy_o,
    output logic          sck_sample_edge_o,
    output logic          sck_shift_edge_o,
    output logic          cs_n_falling_edge_o,
    output logic          cs_n_rising_edge_o
);

    localparam int   CW          = (DW > 1) ? $clog2(DW) : 1;
    localparam logic SCK_IDLE    = (CPOL != 0);
    localparam logic SAMPLE_RISE = (CPOL == CPHA);

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic sck_hist_q, sck_hist_d;
    logic cs_hist_q, cs_hist_d;
    logic mosi_hist_q, mosi_hist_d;

    logic samp_stb_q, samp_stb_d;
    logic shift_stb_q, shift_stb_d;
    logic csf_stb_q, csf_stb_d;
    logic csr_stb_q, csr_stb_d;

    logic [DW-1:0] shreg_q, shreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] data_q, data_d;
    logic valid_q, valid_d;
    logic ovr_q, ovr_d;
    logic ferr_q, ferr_d;

    logic sck_last, cs_last, mosi_last;
    logic sck_rise, sck_fall, sel;
    logic consume;

    // Synchronizers and edge detection
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck_i};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};

        sck_last  = sck_sync_q[SYNC_STAGES-1];
        cs_last   = cs_sync_q[SYNC_STAGES-1];
        mosi_last = mosi_sync_q[SYNC_STAGES-1];

        sck_hist_d  = sck_last;
        cs_hist_d   = cs_last;
        mosi_hist_d = mosi_last;

        sck_rise = sck_last & ~sck_hist_q;
        sck_fall = ~sck_last & sck_hist_q;
        // A CS_N rise in this cycle leaves cs_last high, masking SCK.
        sel      = ~cs_last;

        samp_stb_d  = sel & (SAMPLE_RISE ? sck_rise : sck_fall);
        shift_stb_d = sel & (SAMPLE_RISE ? sck_fall : sck_rise);
        csf_stb_d   = ~cs_last & cs_hist_q;
        csr_stb_d   = cs_last & ~cs_hist_q;
    end

    // Shift register, bit counter and output register.
    // The strobes are registered, so mosi_hist_q is the MOSI level that
    // was in the last sync stage when the sample edge was detected.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        ferr_d  = 1'b0;
        consume = valid_q & ready_i;

        if (consume) begin
            valid_d = 1'b0;
        end

        if (csf_stb_q) begin
            cnt_d   = '0;
            shreg_d = '0;
        end else if (csr_stb_q) begin
            cnt_d = '0;
            if (cnt_q != '0) begin
                ferr_d = 1'b1;
            end
        end else if (samp_stb_q) begin
            shreg_d = {shreg_q[DW-2:0], mosi_hist_q};
            if (cnt_q == CW'(DW - 1)) begin
                cnt_d = '0;
                if (!valid_q || consume) begin
                    data_d  = shreg_d;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q  <= {SYNC_STAGES{SCK_IDLE}};
            cs_sync_q   <= {SYNC_STAGES{1'b1}};
            mosi_sync_q <= '0;
            sck_hist_q  <= SCK_IDLE;
            cs_hist_q   <= 1'b1;
            mosi_hist_q <= 1'b0;
            samp_stb_q  <= 1'b0;
            shift_stb_q <= 1'b0;
            csf_stb_q   <= 1'b0;
            csr_stb_q   <= 1'b0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_hist_q  <= sck_hist_d;
            cs_hist_q   <= cs_hist_d;
            mosi_hist_q <= mosi_hist_d;
            samp_stb_q  <= samp_stb_d;
            shift_stb_q <= shift_stb_d;
            csf_stb_q   <= csf_stb_d;
            csr_stb_q   <= csr_stb_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
            ferr_q      <= ferr_d;
        end
    end

    assign data_o              = data_q;
    assign valid_o             = valid_q;
    assign overrun_o           = ovr_q;
    assign frame_err_o         = ferr_q;
    assign busy_o              = ~cs_sync_q[SYNC_STAGES-1];
    assign sck_sample_edge_o   = samp_stb_q;
    assign sck_shift_edge_o    = shift_stb_q;
    assign cs_n_falling_edge_o = csf_stb_q;
    assign cs_n_rising_edge_o  = csr_stb_q;

endmodule

// File: tb/tb_spi_deserializer.sv
// Testbench for spi_deserializer: one instance per SPI mode sharing CS_N,
// MOSI and ready; each instance has its own SCK pin.
module tb_spi_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] sck;
    logic       cs_n, mosi, ready;

    logic [7:0] data [4];
    logic [3:0] valid, ovr, ferr, busy, samp, shft, csf, csr;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_deserializer #(
            .DW(8), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .sck_i(sck[g]),
            .cs_n_i(cs_n),
            .mosi_i(mosi),
            .data_o(data[g]),
            .valid_o(valid[g]),
            .ready_i(ready),
            .overrun_o(ovr[g]),
            .frame_err_o(ferr[g]),
            .busy_o(busy[g]),
            .sck_sample_edge_o(samp[g]),
            .sck_shift_edge_o(shft[g]),
            .cs_n_falling_edge_o(csf[g]),
            .cs_n_rising_edge_o(csr[g])
        );
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                      nm, act, act, exp, exp);
    endtask

    // Monitor of the instance under test
    int cur = 0;
    int cyc = 0;
    int samp_cnt, pol_bad, wid_bad, lat_bad, last_samp;
    int ovr_cnt, ferr_cnt, stb_cnt;
    logic prev_samp, prev_valid;
    logic [7:0] rxq [$];

    always @(negedge clk) begin
        logic exp_lvl;
        cyc++;
        exp_lvl = ((cur / 2) == (cur % 2));
        if (!rst) begin
            if (samp[cur]) begin
                samp_cnt++;
                if (sck[cur] != exp_lvl) pol_bad++;
                if (prev_samp) wid_bad++;
                last_samp = cyc;
            end
            if (valid[cur] && !prev_valid && cyc != last_samp + 1)
                lat_bad++;
            if (valid[cur] && ready) rxq.push_back(data[cur]);
            ovr_cnt  += int'(ovr[cur]);
            ferr_cnt += int'(ferr[cur]);
            stb_cnt  += int'(samp[cur] | shft[cur] | csf[cur] | csr[cur]);
        end
        prev_samp  = samp[cur];
        prev_valid = valid[cur];
    end

    task automatic clear_mon();
        samp_cnt = 0; pol_bad = 0; wid_bad = 0; lat_bad = 0;
        last_samp = -10; ovr_cnt = 0; ferr_cnt = 0; stb_cnt = 0;
        prev_samp = 1'b0;
        prev_valid = valid[cur];
        rxq.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // f_clk = 8 * f_sck: each SCK phase lasts 4 clk periods
    task automatic send_bits(input int m, input int n, input logic [31:0] bits);
        logic cpol, cpha;
        cpol = m[1];
        cpha = m[0];
        for (int i = n - 1; i >= 0; i--) begin
            if (!cpha) begin
                mosi = bits[i];
                tick(4);
                sck[m] = ~cpol;
                tick(4);
                sck[m] = cpol;
            end else begin
                sck[m] = ~cpol;
                mosi = bits[i];
                tick(4);
                sck[m] = cpol;
                tick(4);
            end
        end
    endtask

    task automatic frame(input int m, input int n, input logic [31:0] bits,
                         input logic rdy);
        cur = m;
        ready = rdy;
        clear_mon();
        cs_n = 1'b0;
        tick(4);
        send_bits(m, n, bits);
        tick(4);
        cs_n = 1'b1;
        tick(8);
    endtask

    task automatic check_common(input string tag, input int n,
                                input int exp_ferr, input int exp_ovr);
        chk({tag, " sample_count"}, samp_cnt, n);
        chk({tag, " sample_polarity"}, pol_bad, 0);
        chk({tag, " strobe_width"}, wid_bad, 0);
        chk({tag, " valid_latency"}, lat_bad, 0);
        chk({tag, " frame_err"}, ferr_cnt, exp_ferr);
        chk({tag, " overrun"}, ovr_cnt, exp_ovr);
    endtask

    typedef struct {
        int         mode;
        int         nbits;
        logic [31:0] bits;
        logic       rdy;
        int         nw;
        logic [7:0] w0;
        logic [7:0] w1;
        int         ferr;
        int         ovr;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k_busy, k_csf, n_csf;
        tbl[0] = '{0, 8,  32'hA5,   1'b1, 1, 8'hA5, 8'h00, 0, 0};
        tbl[1] = '{0, 16, 32'h3CC3, 1'b1, 2, 8'h3C, 8'hC3, 0, 0};
        tbl[2] = '{0, 16, 32'h1122, 1'b0, 1, 8'h11, 8'h00, 0, 1};
        tbl[3] = '{0, 5,  32'h15,   1'b1, 0, 8'h00, 8'h00, 1, 0};
        tbl[4] = '{0, 8,  32'h7E,   1'b1, 1, 8'h7E, 8'h00, 0, 0};
        tbl[5] = '{1, 8,  32'h96,   1'b1, 1, 8'h96, 8'h00, 0, 0};
        tbl[6] = '{2, 8,  32'h96,   1'b1, 1, 8'h96, 8'h00, 0, 0};
        tbl[7] = '{3, 8,  32'h96,   1'b1, 1, 8'h96, 8'h00, 0, 0};

        rst = 1'b1;
        sck = 4'b1100;
        cs_n = 1'b1;
        mosi = 1'b0;
        ready = 1'b1;
        clear_mon();
        tick(3);

        // Reset state of every instance
        chk("reset valid", int'(valid), 0);
        chk("reset overrun", int'(ovr), 0);
        chk("reset frame_err", int'(ferr), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset strobes", int'(samp | shft | csf | csr), 0);
        for (int g = 0; g < 4; g++) chk("reset data", int'(data[g]), 0);

        rst = 1'b0;
        cur = 0;
        clear_mon();
        tick(6);
        chk("post-reset strobes", stb_cnt, 0);

        // CS_N pin-to-output latency, no bits in the frame
        k_busy = 0; k_csf = 0; n_csf = 0;
        cs_n = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (busy[0] && k_busy == 0) k_busy = k;
            if (csf[0]) begin
                n_csf++;
                if (k_csf == 0) k_csf = k;
            end
        end
        chk("busy latency", k_busy, 3);
        chk("cs_fall latency", k_csf, 4);
        chk("cs_fall width", n_csf, 1);
        tick(1);
        cs_n = 1'b1;
        tick(8);
        chk("empty frame frame_err", ferr_cnt, 0);

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            frame(tbl[i].mode, tbl[i].nbits, tbl[i].bits, tbl[i].rdy);
            if (tbl[i].rdy) begin
                chk({tag, " words"}, rxq.size(), tbl[i].nw);
                if (tbl[i].nw > 0 && rxq.size() > 0)
                    chk({tag, " word0"}, int'(rxq[0]), int'(tbl[i].w0));
                if (tbl[i].nw > 1 && rxq.size() > 1)
                    chk({tag, " word1"}, int'(rxq[1]), int'(tbl[i].w1));
                chk({tag, " valid_end"}, int'(valid[cur]), 0);
            end else begin
                chk({tag, " held data"}, int'(data[cur]), int'(tbl[i].w0));
                chk({tag, " held valid"}, int'(valid[cur]), 1);
            end
            check_common(tag, tbl[i].nbits, tbl[i].ferr, tbl[i].ovr);
            if (!tbl[i].rdy) begin
                ready = 1'b1;
                tick(3);
                chk({tag, " drained"}, int'(valid[cur]), 0);
            end
        end

        // Reset in the middle of a frame
        cur = 0;
        clear_mon();
        cs_n = 1'b0;
        tick(4);
        send_bits(0, 4, 32'hA);
        rst = 1'b1;
        tick(1);
        chk("midreset data", int'(data[0]), 0);
        chk("midreset valid", int'(valid[0]), 0);
        chk("midreset busy", int'(busy[0]), 0);
        chk("midreset strobes",
            int'(samp[0] | shft[0] | csf[0] | csr[0]), 0);
        cs_n = 1'b1;
        tick(2);
        rst = 1'b0;
        clear_mon();
        tick(10);
        chk("midreset spurious strobes", stb_cnt, 0);
        chk("midreset frame_err", ferr_cnt, 0);
        frame(0, 8, 32'h5A, 1'b1);
        chk("after reset words", rxq.size(), 1);
        if (rxq.size() > 0) chk("after reset word", int'(rxq[0]), 'h5A);
        check_common("after reset", 8, 0, 0);

        // Randomized frames against a word-chunking reference model
        for (int r = 0; r < 20; r++) begin
            int m, n, nw, exp_ovr;
            logic [31:0] bits;
            logic rdy;
            logic [7:0] w [3];
            string tag;
            m    = $urandom_range(0, 3);
            n    = $urandom_range(1, 24);
            bits = $urandom;
            rdy  = 1'($urandom_range(0, 1));
            tag  = $sformatf("rand%0d", r);
            nw   = n / 8;
            for (int k = 0; k < 3; k++) w[k] = 8'h00;
            for (int k = 0; k < nw; k++) w[k] = bits[n - 1 - 8 * k -: 8];
            exp_ovr = (!rdy && nw > 1) ? nw - 1 : 0;
            frame(m, n, bits, rdy);
            if (rdy) begin
                chk({tag, " words"}, rxq.size(), nw);
                for (int k = 0; k < nw && k < rxq.size(); k++)
                    chk({tag, " word"}, int'(rxq[k]), int'(w[k]));
            end else begin
                chk({tag, " held valid"}, int'(valid[cur]), int'(nw > 0));
                if (nw > 0)
                    chk({tag, " held data"}, int'(data[cur]), int'(w[0]));
            end
            check_common(tag, n, int'(n % 8 != 0), exp_ovr);
            ready = 1'b1;
            tick(3);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
